// File: rtl/d5m_stream_capture_if.sv
// Avalon-ST video source bus between the D5M capture block and the frame-buffer writer.
// The master drives pixel data and framing, and the slave returns ready.
interface d5m_stream_capture_if #(
  parameter int PIX_W = 12
) ();
  logic [PIX_W-1:0] data;
  logic             valid;
  logic             ready;
  logic             startofpacket;
  logic             endofpacket;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );
endinterface

// File: rtl/d5m_stream_capture.sv
// D5M sensor FVAL/LVAL/pixel bus to Avalon-ST video packets. Adds a runtime crop
// window, ready-based overflow detection and geometry error pulses.
module d5m_stream_capture #(
  parameter int PIX_W = 12,
  parameter int COLS  = 2592,
  parameter int LINES = 1944,
  parameter int CNT_W = $clog2(((COLS > LINES) ? COLS : LINES) + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 frame_valid_i,
  input  logic                 line_valid_i,
  input  logic [PIX_W-1:0]     data_in_i,
  input  logic [CNT_W-1:0]     win_x0_i,
  input  logic [CNT_W-1:0]     win_y0_i,
  input  logic [CNT_W-1:0]     win_w_i,
  input  logic [CNT_W-1:0]     win_h_i,
  d5m_stream_capture_if.master src,
  output logic                 frame_done_o,
  output logic [15:0]          frame_count_o,
  output logic                 err_short_line_o,
  output logic                 err_short_frame_o,
  output logic                 err_overflow_o,
  output logic                 busy_o
);
  localparam logic [CNT_W-1:0] COLS_C  = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] LINES_C = CNT_W'(LINES);
  localparam logic [CNT_W:0]   COLS_X  = (CNT_W+1)'(COLS);
  localparam logic [CNT_W:0]   LINES_X = (CNT_W+1)'(LINES);
  localparam logic [CNT_W:0]   ONE_X   = (CNT_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DROP} state_e;
  state_e state_q, state_d;

  logic             fv_q, fv_prev_q, lv_q, lv_prev_q;
  logic [PIX_W-1:0] d_q;
  logic [CNT_W-1:0] col_q, row_q;
  logic             fv_rise, fv_fall, lv_fall, start;

  // fv resets high so a frame already running at reset release is not a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q      <= 1'b1;
      fv_prev_q <= 1'b1;
      lv_q      <= 1'b0;
      lv_prev_q <= 1'b0;
      d_q       <= '0;
    end else begin
      fv_q      <= frame_valid_i;
      fv_prev_q <= fv_q;
      lv_q      <= line_valid_i;
      lv_prev_q <= lv_q;
      d_q       <= data_in_i;
    end
  end

  assign fv_rise = fv_q & ~fv_prev_q;
  assign fv_fall = ~fv_q & fv_prev_q;
  assign lv_fall = ~lv_q & lv_prev_q;
  assign start   = (state_q == S_ARMED) & enable_i & fv_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      if (lv_fall)
        col_q <= '0;
      else if (lv_q && col_q != COLS_C)
        col_q <= col_q + CNT_W'(1);
      if (fv_rise)
        row_q <= '0;
      else if (lv_fall && row_q != LINES_C)
        row_q <= row_q + CNT_W'(1);
    end
  end

  // Window kept as origin plus exclusive end; an unusable request means full frame.
  logic [CNT_W:0] in_xe, in_ye, nx0, ny0, nxe, nye;
  logic           win_bad;
  logic [CNT_W:0] win_x0_q, win_y0_q, win_xe_q, win_ye_q;

  always_comb begin
    in_xe   = {1'b0, win_x0_i} + {1'b0, win_w_i};
    in_ye   = {1'b0, win_y0_i} + {1'b0, win_h_i};
    win_bad = (win_w_i == '0) || (win_h_i == '0) || (in_xe > COLS_X) || (in_ye > LINES_X);
    nx0     = win_bad ? '0 : {1'b0, win_x0_i};
    ny0     = win_bad ? '0 : {1'b0, win_y0_i};
    nxe     = win_bad ? COLS_X : in_xe;
    nye     = win_bad ? LINES_X : in_ye;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x0_q <= '0;
      win_y0_q <= '0;
      win_xe_q <= '0;
      win_ye_q <= '0;
    end else if (start) begin
      win_x0_q <= nx0;
      win_y0_q <= ny0;
      win_xe_q <= nxe;
      win_ye_q <= nye;
    end
  end

  // On the fv_rise cycle the latch and row clear are not yet visible; bypass them.
  logic [CNT_W:0] ex0, ey0, exe, eye, col_x, row_x;
  logic           in_win, sop_hit, eop_hit;

  always_comb begin
    ex0     = fv_rise ? nx0 : win_x0_q;
    ey0     = fv_rise ? ny0 : win_y0_q;
    exe     = fv_rise ? nxe : win_xe_q;
    eye     = fv_rise ? nye : win_ye_q;
    col_x   = {1'b0, col_q};
    row_x   = fv_rise ? '0 : {1'b0, row_q};
    in_win  = lv_q && (col_x < COLS_X) && (col_x >= ex0) && (col_x < exe)
              && (row_x >= ey0) && (row_x < eye);
    sop_hit = in_win && (col_x == ex0) && (row_x == ey0);
    eop_hit = in_win && ((col_x + ONE_X) == exe) && ((row_x + ONE_X) == eye);
  end

  logic             pix_valid_q, pix_sop_q, pix_eop_q;
  logic [PIX_W-1:0] pix_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_sop_q   <= 1'b0;
      pix_eop_q   <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      pix_valid_q <= in_win;
      pix_sop_q   <= sop_hit;
      pix_eop_q   <= eop_hit;
      pix_data_q  <= d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  logic beat_fire, beat_eop, overflow, short_line, short_frame, busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable_i) state_d = S_ARMED;
      S_ARMED: begin
        if (!enable_i)    state_d = S_IDLE;
        else if (fv_rise) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (beat_eop || overflow) state_d = S_DROP;
        else if (short_frame)     state_d = enable_i ? S_ARMED : S_IDLE;
      end
      S_DROP:    if (!fv_q) state_d = enable_i ? S_ARMED : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ready is judged on the cycle the beat is formed; a refused pixel is lost.
  always_comb begin
    beat_fire   = (state_q == S_CAPTURE) && pix_valid_q && src.ready;
    beat_eop    = beat_fire && pix_eop_q;
    overflow    = (state_q == S_CAPTURE) && pix_valid_q && !src.ready;
    short_line  = (state_q == S_CAPTURE) && lv_fall && (col_q < COLS_C);
    short_frame = (state_q == S_CAPTURE) && fv_fall && !beat_eop && !overflow;
    busy        = (state_q == S_CAPTURE) || (state_q == S_DROP);
  end

  logic [PIX_W-1:0] data_out_q;
  logic             data_valid_q, sop_q, eop_q, frame_done_q;
  logic             err_sl_q, err_sf_q, err_ov_q;
  logic [15:0]      frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_sl_q      <= 1'b0;
      err_sf_q      <= 1'b0;
      err_ov_q      <= 1'b0;
    end else begin
      if (beat_fire) data_out_q <= pix_data_q;
      data_valid_q  <= beat_fire;
      sop_q         <= beat_fire && pix_sop_q;
      eop_q         <= beat_eop;
      frame_done_q  <= data_valid_q && eop_q;
      frame_count_q <= frame_count_q + 16'(data_valid_q && eop_q);
      err_sl_q      <= short_line;
      err_sf_q      <= short_frame;
      err_ov_q      <= overflow;
    end
  end

  assign src.data          = data_out_q;
  assign src.valid         = data_valid_q;
  assign src.startofpacket = sop_q;
  assign src.endofpacket   = eop_q;
  assign frame_done_o      = frame_done_q;
  assign frame_count_o     = frame_count_q;
  assign err_short_line_o  = err_sl_q;
  assign err_short_frame_o = err_sf_q;
  assign err_overflow_o    = err_ov_q;
  assign busy_o            = busy;
endmodule

// File: tb/tb_d5m_stream_capture.sv
// Directed bench for d5m_stream_capture on an 8x4 sensor; pixel value = row*16+col.
module tb_d5m_stream_capture;
  localparam int PIX_W = 12;
  localparam int COLS  = 8;
  localparam int LINES = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             fv = 1'b0;
  logic             lv = 1'b0;
  logic [PIX_W-1:0] din = '0;
  logic [CNT_W-1:0] wx0 = '0, wy0 = '0, ww = '0, wh = '0;
  logic             frame_done, e_sl, e_sf, e_ov, busy;
  logic [15:0]      frame_count;

  d5m_stream_capture_if #(.PIX_W(PIX_W)) av ();

  d5m_stream_capture #(.PIX_W(PIX_W), .COLS(COLS), .LINES(LINES), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_i          (enable),
    .frame_valid_i     (fv),
    .line_valid_i      (lv),
    .data_in_i         (din),
    .win_x0_i          (wx0),
    .win_y0_i          (wy0),
    .win_w_i           (ww),
    .win_h_i           (wh),
    .src               (av),
    .frame_done_o      (frame_done),
    .frame_count_o     (frame_count),
    .err_short_line_o  (e_sl),
    .err_short_frame_o (e_sf),
    .err_overflow_o    (e_ov),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, edge_cnt = 0;
  int q_data[$];
  int sop_cnt, eop_cnt, sop_idx, eop_idx, fd_cnt, sl_cnt, sf_cnt, ov_cnt;
  int first_beat_edge, first_drive_edge, eop_edge, fd_edge;
  bit rp0 = 1'b1, rp1 = 1'b1;
  int exp_win[6] = '{18, 19, 20, 34, 35, 36};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else
      $display("ok   %s = %0d", tag, got);
  endtask

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    #1;
    if (av.valid) begin
      if (q_data.size() == 0) first_beat_edge = edge_cnt;
      if (av.startofpacket) begin sop_cnt++; sop_idx = q_data.size(); end
      if (av.endofpacket) begin eop_cnt++; eop_idx = q_data.size(); eop_edge = edge_cnt; end
      q_data.push_back(int'(av.data));
    end
    if (frame_done) begin fd_cnt++; fd_edge = edge_cnt; end
    sl_cnt += int'(e_sl);
    sf_cnt += int'(e_sf);
    ov_cnt += int'(e_ov);
  end

  task automatic clear_mon();
    q_data.delete();
    sop_cnt = 0; eop_cnt = 0; sop_idx = -1; eop_idx = -1;
    fd_cnt = 0; sl_cnt = 0; sf_cnt = 0; ov_cnt = 0;
    first_beat_edge = -1; eop_edge = -1; fd_edge = -1;
  endtask

  // ready for a pixel is applied two steps after the pixel itself is driven.
  task automatic step(input bit f, input bit l, input int d, input bit rplan);
    @(negedge clk);
    fv = f;
    lv = l;
    din = PIX_W'(d);
    av.ready = rp1;
    rp1 = rp0;
    rp0 = rplan;
  endtask

  task automatic drive_frame(input int nlines, input int odd_row, input int odd_len, input int ovf_idx);
    int p = 0;
    repeat (2) step(1'b0, 1'b0, 0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 0, 1'b1);
    for (int r = 0; r < nlines; r++) begin
      int len = (r == odd_row) ? odd_len : COLS;
      for (int c = 0; c < len; c++) begin
        step(1'b1, 1'b1, r * 16 + c, p != ovf_idx);
        if (p == 0) first_drive_edge = edge_cnt + 1;
        p++;
      end
      repeat (3) step(1'b1, 1'b0, 0, 1'b1);
    end
    repeat (6) step(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic set_win(input int x0, input int y0, input int w, input int h);
    wx0 = CNT_W'(x0); wy0 = CNT_W'(y0); ww = CNT_W'(w); wh = CNT_W'(h);
  endtask

  initial begin
    av.ready = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(av.valid), 0);
    chk("rst_data", int'(av.data), 0);
    chk("rst_sop_eop", int'({av.startofpacket, av.endofpacket}), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_count", int'(frame_count), 0);
    chk("rst_err", int'({e_sl, e_sf, e_ov}), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    enable = 1'b1;

    // full frame via invalid window
    clear_mon();
    drive_frame(4, -1, 0, -1);
    chk("full_beats", q_data.size(), 32);
    chk("full_sop_cnt", sop_cnt, 1);
    chk("full_sop_idx", sop_idx, 0);
    chk("full_eop_cnt", eop_cnt, 1);
    chk("full_eop_idx", eop_idx, 31);
    if (q_data.size() == 32) begin
      chk("full_d0", q_data[0], 0);
      chk("full_d9", q_data[9], 17);
      chk("full_d31", q_data[31], 55);
    end
    chk("full_latency", first_beat_edge - first_drive_edge, 2);
    chk("full_fd_cnt", fd_cnt, 1);
    chk("full_fd_delay", fd_edge - eop_edge, 1);
    chk("full_count", int'(frame_count), 1);
    chk("full_busy_after", int'(busy), 0);

    // crop window 2,1,3,2
    clear_mon();
    set_win(2, 1, 3, 2);
    drive_frame(4, -1, 0, -1);
    chk("win_beats", q_data.size(), 6);
    if (q_data.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("win_d%0d", i), q_data[i], exp_win[i]);
    chk("win_sop_idx", sop_idx, 0);
    chk("win_eop_idx", eop_idx, 5);
    chk("win_eop_cnt", eop_cnt, 1);
    chk("win_count", int'(frame_count), 2);

    // 1x1 window; inputs changed mid-frame must be ignored
    clear_mon();
    set_win(5, 3, 1, 1);
    fork
      drive_frame(4, -1, 0, -1);
      begin repeat (8) @(negedge clk); set_win(0, 0, 1, 1); end
    join
    chk("w1_beats", q_data.size(), 1);
    if (q_data.size() == 1) chk("w1_data", q_data[0], 53);
    chk("w1_sop_cnt", sop_cnt, 1);
    chk("w1_eop_cnt", eop_cnt, 1);
    chk("w1_same_beat", sop_idx - eop_idx, 0);
    chk("w1_count", int'(frame_count), 3);

    // ready low on the 10th in-window pixel, then a clean frame
    clear_mon();
    set_win(0, 0, 0, 0);
    drive_frame(4, -1, 0, 9);
    chk("ovf_pulses", ov_cnt, 1);
    chk("ovf_beats", q_data.size(), 9);
    if (q_data.size() == 9) chk("ovf_last", q_data[8], 16);
    chk("ovf_eop_cnt", eop_cnt, 0);
    chk("ovf_fd_cnt", fd_cnt, 0);
    chk("ovf_count", int'(frame_count), 3);
    clear_mon();
    drive_frame(4, -1, 0, -1);
    chk("ovf_next_beats", q_data.size(), 32);
    chk("ovf_next_eop", eop_cnt, 1);
    chk("ovf_next_count", int'(frame_count), 4);

    // short line 2, then long line 1
    clear_mon();
    drive_frame(4, 2, 5, -1);
    chk("sl_pulses", sl_cnt, 1);
    chk("sl_beats", q_data.size(), 29);
    chk("sl_eop_idx", eop_idx, 28);
    chk("sl_count", int'(frame_count), 5);
    clear_mon();
    drive_frame(4, 1, 10, -1);
    chk("long_sl", sl_cnt, 0);
    chk("long_beats", q_data.size(), 32);
    if (q_data.size() == 32) chk("long_d15", q_data[15], 23);
    chk("long_count", int'(frame_count), 6);

    // frame ends after 2 lines
    clear_mon();
    drive_frame(2, -1, 0, -1);
    chk("sf_pulses", sf_cnt, 1);
    chk("sf_beats", q_data.size(), 16);
    chk("sf_eop_cnt", eop_cnt, 0);
    chk("sf_fd_cnt", fd_cnt, 0);
    chk("sf_count", int'(frame_count), 6);
    chk("sf_busy", int'(busy), 0);

    // reset asserted mid-frame and released while frame_valid is high
    clear_mon();
    fork
      drive_frame(4, -1, 0, -1);
      begin
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", int'(av.valid), 0);
        clear_mon();
        rst = 1'b0;
      end
    join
    chk("rstmid_beats", q_data.size(), 0);
    chk("rstmid_fd", fd_cnt, 0);
    chk("rstmid_count", int'(frame_count), 0);

    // enable dropped mid-frame: packet completes, next frame ignored
    clear_mon();
    fork
      drive_frame(4, -1, 0, -1);
      begin repeat (15) @(negedge clk); enable = 1'b0; end
    join
    chk("en_beats", q_data.size(), 32);
    chk("en_eop_idx", eop_idx, 31);
    chk("en_count", int'(frame_count), 1);
    clear_mon();
    fork
      drive_frame(4, -1, 0, -1);
      begin repeat (20) @(negedge clk); chk("ign_busy", int'(busy), 0); end
    join
    chk("ign_beats", q_data.size(), 0);
    chk("ign_count", int'(frame_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
